// File: rtl/hc595_clock_display_if.sv
// Pin bundle between the clock/display core and a 74HC595 shift-register chain.
// The master drives the pins; a board model or bench observes them through the slave modport.
interface hc595_clock_display_if;
    logic ds;
    logic shcp;
    logic stcp;
    logic oe;

    modport master (output ds, output shcp, output stcp, output oe);
    modport slave  (input  ds, input  shcp, input  stcp, input  oe);
endinterface

// File: rtl/hc595_clock_display.sv
// Settable HH:MM:SS clock with 12/24-h BCD outputs, a 1 Hz tick, and a multiplexed
// 74HC595 serial driver that scans 4 or 6 seven-segment digits.
module hc595_clock_display #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned SHCP_DIV       = 4,
    parameter int unsigned SCAN_CYCLES    = 50_000,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned SEL_ACTIVE_LOW = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         mode_12h,
    input  logic                         load,
    input  logic [4:0]                   load_h,
    input  logic [5:0]                   load_m,
    input  logic [5:0]                   load_s,
    output logic [7:0]                   hours_o,
    output logic [7:0]                   minutes_o,
    output logic [7:0]                   seconds_o,
    output logic                         pm_o,
    output logic                         sec_tick,
    hc595_clock_display_if.master        hc595
);

    localparam int unsigned TBW     = $clog2(CLK_FREQ);
    localparam int unsigned FRAME_W = 8 + DIGITS;
    localparam int unsigned BCW     = $clog2(FRAME_W);
    localparam int unsigned DVW     = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
    localparam int unsigned SCW     = $clog2(SCAN_CYCLES + 1) + 1;
    localparam int unsigned IXW     = $clog2(DIGITS);

    localparam logic [TBW-1:0]    TB_LAST   = TBW'(CLK_FREQ - 1);
    localparam logic [BCW-1:0]    BIT_LAST  = BCW'(FRAME_W - 1);
    localparam logic [DVW-1:0]    DIV_LAST  = DVW'(SHCP_DIV - 1);
    localparam logic [SCW-1:0]    SCAN_LAST = SCW'(SCAN_CYCLES - 1);
    localparam logic [IXW-1:0]    IDX_LAST  = IXW'(DIGITS - 1);
    localparam logic [2:0]        POS_OFF   = (DIGITS == 4) ? 3'd2 : 3'd0;
    localparam logic [DIGITS-1:0] SEL_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

    if (DIGITS != 4 && DIGITS != 6) begin : g_bad_digits
        $error("hc595_clock_display: DIGITS must be 4 or 6");
    end

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH, S_DWELL} state_t;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        t = 4'd0;
        for (int unsigned i = 1; i <= 5; i++) begin
            if (v >= 7'(i * 10)) t = 4'(i);
        end
        return {t, 4'(v - 7'(t) * 7'd10)};
    endfunction

    // Active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // ---------------- timekeeping ----------------
    logic [TBW-1:0] r_tb;
    logic [4:0]     r_h;
    logic [5:0]     r_m;
    logic [5:0]     r_s;
    logic           r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tb   <= '0;
            r_h    <= '0;
            r_m    <= '0;
            r_s    <= '0;
            r_tick <= 1'b0;
        end else if (load) begin
            r_h    <= (load_h > 5'd23) ? 5'd23 : load_h;
            r_m    <= (load_m > 6'd59) ? 6'd59 : load_m;
            r_s    <= (load_s > 6'd59) ? 6'd59 : load_s;
            r_tb   <= '0;
            r_tick <= 1'b0;
        end else if (en && r_tb == TB_LAST) begin
            r_tb   <= '0;
            r_tick <= 1'b1;
            if (r_s == 6'd59) begin
                r_s <= '0;
                if (r_m == 6'd59) begin
                    r_m <= '0;
                    r_h <= (r_h == 5'd23) ? 5'd0 : r_h + 5'd1;
                end else begin
                    r_m <= r_m + 6'd1;
                end
            end else begin
                r_s <= r_s + 6'd1;
            end
        end else begin
            r_tick <= 1'b0;
            if (en) r_tb <= r_tb + 1'b1;
        end
    end

    // ---------------- registered BCD view ----------------
    logic [4:0] w_h12;
    logic [7:0] r_hr_bcd;
    logic [7:0] r_min_bcd;
    logic [7:0] r_sec_bcd;
    logic       r_pm;
    logic       r_mode12;

    always_comb begin
        w_h12 = r_h;
        if (r_h == 5'd0)       w_h12 = 5'd12;
        else if (r_h > 5'd12)  w_h12 = r_h - 5'd12;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hr_bcd  <= '0;
            r_min_bcd <= '0;
            r_sec_bcd <= '0;
            r_pm      <= 1'b0;
            r_mode12  <= 1'b0;
        end else begin
            r_hr_bcd  <= to_bcd({2'b00, mode_12h ? w_h12 : r_h});
            r_min_bcd <= to_bcd({1'b0, r_m});
            r_sec_bcd <= to_bcd({1'b0, r_s});
            r_pm      <= (r_h >= 5'd12);
            r_mode12  <= mode_12h;
        end
    end

    assign hours_o   = r_hr_bcd;
    assign minutes_o = r_min_bcd;
    assign seconds_o = r_sec_bcd;
    assign pm_o      = r_pm;
    assign sec_tick  = r_tick;

    // ---------------- frame builder ----------------
    logic [IXW-1:0]     r_idx;
    logic [2:0]         w_pos;
    logic [3:0]         w_nib;
    logic               w_dp;
    logic               w_blank;
    logic [7:0]         w_seg_hi;
    logic [7:0]         w_seg;
    logic [DIGITS-1:0]  w_sel;
    logic [FRAME_W-1:0] w_frame;

    // 4-digit boards start at minutes, so map index onto the 6-digit position space
    always_comb begin
        w_pos = 3'(r_idx) + POS_OFF;
        case (w_pos)
            3'd0:    w_nib = r_sec_bcd[3:0];
            3'd1:    w_nib = r_sec_bcd[7:4];
            3'd2:    w_nib = r_min_bcd[3:0];
            3'd3:    w_nib = r_min_bcd[7:4];
            3'd4:    w_nib = r_hr_bcd[3:0];
            default: w_nib = r_hr_bcd[7:4];
        endcase
        w_dp     = r_sec_bcd[0] && (w_pos == 3'd4 || (w_pos == 3'd2 && DIGITS == 6));
        w_blank  = (w_pos == 3'd5) && r_mode12 && (r_hr_bcd[7:4] == 4'd0);
        w_seg_hi = w_blank ? 8'h00 : {w_dp, seg7(w_nib)};
        w_seg    = (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
        w_sel    = (SEL_ACTIVE_LOW != 0) ? ~(SEL_ONE << r_idx) : (SEL_ONE << r_idx);
        w_frame  = {w_sel, w_seg};
    end

    // ---------------- scan FSM ----------------
    state_t             r_state, w_nxt_state;
    logic [FRAME_W-2:0] r_frame, w_nxt_frame;
    logic [BCW-1:0]     r_bit,   w_nxt_bit;
    logic [DVW-1:0]     r_div,   w_nxt_div;
    logic               r_phase, w_nxt_phase;
    logic [SCW-1:0]     r_scan,  w_nxt_scan;
    logic [IXW-1:0]     w_nxt_idx;
    logic               r_ds,   w_nxt_ds;
    logic               r_shcp, w_nxt_shcp;
    logic               r_stcp, w_nxt_stcp;
    logic               r_oe,   w_nxt_oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_frame <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_scan  <= '0;
            r_idx   <= '0;
            r_ds    <= 1'b0;
            r_shcp  <= 1'b0;
            r_stcp  <= 1'b0;
            r_oe    <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_frame <= w_nxt_frame;
            r_bit   <= w_nxt_bit;
            r_div   <= w_nxt_div;
            r_phase <= w_nxt_phase;
            r_scan  <= w_nxt_scan;
            r_idx   <= w_nxt_idx;
            r_ds    <= w_nxt_ds;
            r_shcp  <= w_nxt_shcp;
            r_stcp  <= w_nxt_stcp;
            r_oe    <= w_nxt_oe;
        end
    end

    // Pins are registered next-state values; r_frame holds only the bits not yet on ds
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_frame = r_frame;
        w_nxt_bit   = r_bit;
        w_nxt_div   = r_div;
        w_nxt_phase = r_phase;
        w_nxt_scan  = (r_scan == '1) ? r_scan : r_scan + 1'b1;
        w_nxt_idx   = r_idx;
        w_nxt_ds    = r_ds;
        w_nxt_shcp  = r_shcp;
        w_nxt_stcp  = r_stcp;
        w_nxt_oe    = r_oe;
        case (r_state)
            S_LOAD: begin
                w_nxt_state = S_SHIFT;
                w_nxt_frame = w_frame[FRAME_W-2:0];
                w_nxt_ds    = w_frame[FRAME_W-1];
                w_nxt_bit   = BIT_LAST;
                w_nxt_div   = '0;
                w_nxt_phase = 1'b0;
                w_nxt_shcp  = 1'b0;
            end
            S_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_nxt_div = '0;
                    if (!r_phase) begin
                        w_nxt_phase = 1'b1;
                        w_nxt_shcp  = 1'b1;
                    end else begin
                        w_nxt_phase = 1'b0;
                        w_nxt_shcp  = 1'b0;
                        if (r_bit == '0) begin
                            w_nxt_state = S_LATCH;
                            w_nxt_stcp  = 1'b1;
                        end else begin
                            w_nxt_bit   = r_bit - 1'b1;
                            w_nxt_ds    = r_frame[FRAME_W-2];
                            w_nxt_frame = {r_frame[FRAME_W-3:0], 1'b0};
                        end
                    end
                end else begin
                    w_nxt_div = r_div + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_div == DIV_LAST) begin
                    w_nxt_div   = '0;
                    w_nxt_stcp  = 1'b0;
                    w_nxt_oe    = 1'b0;
                    w_nxt_state = S_DWELL;
                end else begin
                    w_nxt_div = r_div + 1'b1;
                end
            end
            S_DWELL: begin
                if (r_scan >= SCAN_LAST) begin
                    w_nxt_state = S_LOAD;
                    w_nxt_scan  = '0;
                    w_nxt_idx   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end
            end
            default: w_nxt_state = S_LOAD;
        endcase
    end

    assign hc595.ds   = r_ds;
    assign hc595.shcp = r_shcp;
    assign hc595.stcp = r_stcp;
    assign hc595.oe   = r_oe;

endmodule

// File: tb/tb_hc595_clock_display.sv
// Bench for hc595_clock_display: latched HC595 frames are checked against a queue of
// hand-computed frames by a pin monitor; time/BCD behaviour is checked directly.
module tb_hc595_clock_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode_12h = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_h = '0;
    logic [5:0] load_m = '0;
    logic [5:0] load_s = '0;
    logic [7:0] hours_o, minutes_o, seconds_o;
    logic       pm_o, sec_tick;

    hc595_clock_display_if pins();

    hc595_clock_display #(
        .CLK_FREQ(10), .DIGITS(6), .SHCP_DIV(1), .SCAN_CYCLES(64),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .load(load),
        .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hours_o(hours_o), .minutes_o(minutes_o), .seconds_o(seconds_o),
        .pm_o(pm_o), .sec_tick(sec_tick), .hc595(pins)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    logic [13:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- pin monitor / scoreboard ----------------
    logic        prev_shcp = 1'b0, prev_stcp = 1'b0, prev_ds = 1'b0, glitch = 1'b0;
    logic [13:0] cap = '0;
    logic [13:0] mon_exp;
    int          rises = 0, cyc = 0, last_latch = -1, frame_no = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (sec_tick) tick_cnt++;
        if (rst) begin
            cap = '0; rises = 0; glitch = 1'b0; last_latch = -1;
        end else begin
            if (pins.ds !== prev_ds && pins.shcp) glitch = 1'b1;
            if (!prev_shcp && pins.shcp) begin
                cap = {cap[12:0], pins.ds};
                rises++;
            end
            if (!prev_stcp && pins.stcp) begin
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    frame_no++;
                    check($sformatf("frame%0d_bits", frame_no), 32'(cap), 32'(mon_exp));
                    check($sformatf("frame%0d_shcp_rises", frame_no), rises, 14);
                    check($sformatf("frame%0d_ds_stable", frame_no), 32'(glitch), 0);
                    if (last_latch >= 0)
                        check($sformatf("frame%0d_period", frame_no), cyc - last_latch, 64);
                end
                last_latch = cyc; cap = '0; rises = 0; glitch = 1'b0;
            end
        end
        prev_shcp = pins.shcp;
        prev_stcp = pins.stcp;
        prev_ds   = pins.ds;
    end

    // ---------------- stimulus ----------------
    task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        load_h = h; load_m = m; load_s = s; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        for (int n = 0; n < limit && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL frame_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic pm);
        check({tag, "_hours"}, 32'(hours_o), 32'(h));
        check({tag, "_minutes"}, 32'(minutes_o), 32'(m));
        check({tag, "_seconds"}, 32'(seconds_o), 32'(s));
        check({tag, "_pm"}, 32'(pm_o), 32'(pm));
    endtask

    int t0, seen, at_i;
    bit got_shcp;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_time("rst", 8'h00, 8'h00, 8'h00, 1'b0);
        check("rst_sec_tick", 32'(sec_tick), 0);
        check("rst_ds", 32'(pins.ds), 0);
        check("rst_shcp", 32'(pins.shcp), 0);
        check("rst_stcp", 32'(pins.stcp), 0);
        check("rst_oe", 32'(pins.oe), 1);

        // first frame is snapshotted before the load lands: digit0 of 00:00:00
        rst = 1'b0;
        exp_q.push_back({6'b111110, 8'b11000000});
        t0 = tick_cnt;
        do_load(5'd12, 6'd34, 6'd56);
        wait_empty(200);
        check("oe_before_latch_end", 32'(pins.oe), 1);
        @(negedge clk);
        check("oe_after_first_latch", 32'(pins.oe), 0);

        // en=0: frozen 12:34:56, index walks 1..5 then wraps to 0
        exp_q.push_back({6'b111101, 8'b10010010});
        exp_q.push_back({6'b111011, 8'b10011001});
        exp_q.push_back({6'b110111, 8'b10110000});
        exp_q.push_back({6'b101111, 8'b10100100});
        exp_q.push_back({6'b011111, 8'b11111001});
        exp_q.push_back({6'b111110, 8'b10000010});
        wait_empty(6 * 64 + 100);
        check_time("frozen", 8'h12, 8'h34, 8'h56, 1'b1);
        check("frozen_no_tick", tick_cnt - t0, 0);

        // 12-h 09:05:07: blanked hour tens, dp on h1 and m1 for odd seconds
        mode_12h = 1'b1;
        exp_q.push_back({6'b111101, 8'b11000000});
        exp_q.push_back({6'b111011, 8'b00010010});
        exp_q.push_back({6'b110111, 8'b11000000});
        exp_q.push_back({6'b101111, 8'b00010000});
        exp_q.push_back({6'b011111, 8'b11111111});
        exp_q.push_back({6'b111110, 8'b11111000});
        do_load(5'd9, 6'd5, 6'd7);
        @(negedge clk);
        check_time("h12_09", 8'h09, 8'h05, 8'h07, 1'b0);
        wait_empty(6 * 64 + 100);

        // clamping and 12-h mapping
        mode_12h = 1'b0;
        do_load(5'd30, 6'd61, 6'd5);
        @(negedge clk);
        check_time("clamp", 8'h23, 8'h59, 8'h05, 1'b1);
        mode_12h = 1'b1;
        do_load(5'd0, 6'd0, 6'd0);
        @(negedge clk);
        check("h12_h0_hours", 32'(hours_o), 32'h12);
        check("h12_h0_pm", 32'(pm_o), 0);
        do_load(5'd13, 6'd0, 6'd0);
        @(negedge clk);
        check("h12_h13_hours", 32'(hours_o), 32'h01);
        check("h12_h13_pm", 32'(pm_o), 1);
        mode_12h = 1'b0;
        @(negedge clk);
        check("h24_h13_hours", 32'(hours_o), 32'h13);

        // 23:59:59 rollover with en=1
        en = 1'b1;
        do_load(5'd23, 6'd59, 6'd59);
        seen = 0; at_i = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (sec_tick) begin seen++; at_i = i; end
            if (i == 10) check("roll_bcd_lag_seconds", 32'(seconds_o), 32'h59);
        end
        check("roll_tick_count", seen, 1);
        check("roll_tick_cycle", at_i, 10);
        @(negedge clk);
        check_time("roll", 8'h00, 8'h00, 8'h00, 1'b0);
        check("roll_tick_cleared", 32'(sec_tick), 0);

        // load on the tick cycle wins
        do_load(5'd1, 6'd2, 6'd3);
        t0 = tick_cnt;
        repeat (9) @(negedge clk);
        do_load(5'd4, 6'd5, 6'd6);
        check("loadtick_no_tick", 32'(sec_tick), 0);
        @(negedge clk);
        check_time("loadtick", 8'h04, 8'h05, 8'h06, 1'b0);
        check("loadtick_tick_count", tick_cnt - t0, 0);
        en = 1'b0;

        // reset in the middle of a shift
        got_shcp = 1'b0;
        for (int n = 0; n < 200 && !got_shcp; n++) begin
            @(negedge clk);
            if (pins.shcp) got_shcp = 1'b1;
        end
        check("midshift_found", 32'(got_shcp), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ds", 32'(pins.ds), 0);
        check("midrst_shcp", 32'(pins.shcp), 0);
        check("midrst_stcp", 32'(pins.stcp), 0);
        check("midrst_oe", 32'(pins.oe), 1);
        check_time("midrst", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        exp_q.push_back({6'b111110, 8'b11000000});
        wait_empty(200);
        @(negedge clk);
        check("midrst_oe_after_latch", 32'(pins.oe), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        checks++; errors++;
        $display("FAIL watchdog: got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
